bus_arbiter_rr4: RTL and testbench

//  Round-robin arbiter/sequencer sharing one TTL-style peripheral bus between 4 requesters.
//  Per transaction it drives the select/enable of the shared 74253-type 4:1 selector and the

---
 rtl/bus_arbiter_rr4.sv | 180 ++++++++++++++++++
 tb/tb_bus_arbiter_rr4.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr4.sv
// ============================================================================
//  Module   : bus_arbiter_rr4
//  Purpose  : Round-robin arbiter/sequencer sharing one TTL-style peripheral
//             bus between 4 requesters. Drives the 4:1 selector and the
//             3-to-8 chip-select decoder through setup, strobe and recovery
//             phases, then pulses a one-cycle ack to the winner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr4 #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] dev_sel,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic [1:0]  mux_sel,
  output logic        mux_oe_n,
  output logic [2:0]  dec_x,
  output logic        dec_g1,
  output logic        dec_g2a_n,
  output logic        dec_g2b_n,
  output logic        busy
);

  localparam logic [3:0] C_STROBE_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;
  logic        mux_oe_n_q, mux_oe_n_d;
  logic [2:0]  dec_x_q, dec_x_d;
  logic        dec_en_q, dec_en_d;
  logic        busy_q, busy_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [2:0]  win_dev;

  // Round-robin scan: first requester at or after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 2'd0;
    for (int s = 0; s < 4; s++) begin
      cand = ptr_q + 2'(s);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decoder line of the arbitration winner, latched on grant.
  always_comb begin
    win_dev = dev_sel[2:0];
    case (win_idx)
      2'd0: win_dev = dev_sel[2:0];
      2'd1: win_dev = dev_sel[5:3];
      2'd2: win_dev = dev_sel[8:6];
      2'd3: win_dev = dev_sel[11:9];
      default: win_dev = dev_sel[2:0];
    endcase
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = 4'd0;
    mux_oe_n_d = mux_oe_n_q;
    dec_x_d    = dec_x_q;
    dec_en_d   = dec_en_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req != 4'd0) begin
          state_d    = S_SETUP;
          owner_d    = win_idx;
          dec_x_d    = win_dev;
          grant_d    = 4'b0001 << win_idx;
          mux_oe_n_d = 1'b0;
          busy_d     = 1'b1;
          dec_en_d   = 1'b0;
        end
      end
      S_SETUP: begin
        if (!req[owner_q]) begin
          // Owner withdrew before the strobe: recover without ack.
          state_d  = S_RECOVER;
          dec_en_d = 1'b0;
        end else begin
          state_d  = S_STROBE;
          cnt_d    = C_STROBE_LOAD;
          dec_en_d = 1'b1;
        end
      end
      S_STROBE: begin
        if (!req[owner_q]) begin
          // Abort takes precedence even on the final strobe cycle.
          state_d  = S_RECOVER;
          dec_en_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d  = S_RECOVER;
          dec_en_d = 1'b0;
          ack_d    = grant_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        state_d    = S_IDLE;
        grant_d    = 4'd0;
        mux_oe_n_d = 1'b1;
        busy_d     = 1'b0;
        ptr_d      = owner_q + 2'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      grant_q    <= 4'd0;
      ack_q      <= 4'd0;
      mux_oe_n_q <= 1'b1;
      dec_x_q    <= 3'd0;
      dec_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      mux_oe_n_q <= mux_oe_n_d;
      dec_x_q    <= dec_x_d;
      dec_en_q   <= dec_en_d;
      busy_q     <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign mux_sel   = owner_q;
  assign mux_oe_n  = mux_oe_n_q;
  assign dec_x     = dec_x_q;
  assign dec_g1    = dec_en_q;
  assign dec_g2a_n = ~dec_en_q;
  assign dec_g2b_n = ~dec_en_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr4.sv
// ============================================================================
//  Module   : tb_bus_arbiter_rr4
//  Purpose  : Self-checking bench for bus_arbiter_rr4 (WAIT_STATES=2 and 0)
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_rr4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] dev_sel;

  logic [3:0]  g_o [2];
  logic [3:0]  a_o [2];
  logic [1:0]  ms_o [2];
  logic        oe_o [2];
  logic [2:0]  dx_o [2];
  logic        g1_o [2];
  logic        g2a_o [2];
  logic        g2b_o [2];
  logic        b_o [2];

  int errors = 0;
  int checks = 0;

  bus_arbiter_rr4 #(.WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(reset), .req(req), .dev_sel(dev_sel),
    .grant(g_o[0]), .ack(a_o[0]), .mux_sel(ms_o[0]), .mux_oe_n(oe_o[0]),
    .dec_x(dx_o[0]), .dec_g1(g1_o[0]), .dec_g2a_n(g2a_o[0]), .dec_g2b_n(g2b_o[0]),
    .busy(b_o[0])
  );

  bus_arbiter_rr4 #(.WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .req(req), .dev_sel(dev_sel),
    .grant(g_o[1]), .ack(a_o[1]), .mux_sel(ms_o[1]), .mux_oe_n(oe_o[1]),
    .dec_x(dx_o[1]), .dec_g1(g1_o[1]), .dec_g2a_n(g2a_o[1]), .dec_g2b_n(g2b_o[1]),
    .busy(b_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one transaction record per DUT.
  // act = transaction in progress, k = cycles spent since grant (0 = setup),
  // rec = in the recovery cycle, abt = transaction was abandoned.
  int          ws_of [2] = '{2, 0};
  logic        m_act [2] = '{1'b0, 1'b0};
  logic        m_rec [2] = '{1'b0, 1'b0};
  logic        m_abt [2] = '{1'b0, 1'b0};
  int          m_own [2] = '{0, 0};
  int          m_k   [2] = '{0, 0};
  int          m_ptr [2] = '{0, 0};
  logic [2:0]  m_dx  [2] = '{3'd0, 3'd0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic logic       a   = m_act[d];
      automatic logic       r   = m_rec[d];
      automatic logic       ab  = m_abt[d];
      automatic int         o   = m_own[d];
      automatic int         k   = m_k[d];
      automatic int         p   = m_ptr[d];
      automatic logic [2:0] dx  = m_dx[d];
      automatic logic       fnd = 1'b0;
      if (reset) begin
        a = 1'b0; r = 1'b0; ab = 1'b0; o = 0; k = 0; p = 0; dx = 3'd0;
      end else if (!a) begin
        for (int s = 0; s < 4; s++) begin
          if (!fnd && req[(p + s) % 4]) begin
            fnd = 1'b1;
            o   = (p + s) % 4;
          end
        end
        if (fnd) begin
          a = 1'b1; r = 1'b0; ab = 1'b0; k = 0;
          dx = dev_sel[3*o +: 3];
        end
      end else if (r) begin
        a = 1'b0; r = 1'b0; p = (o + 1) % 4;
      end else if (!req[o]) begin
        r = 1'b1; ab = 1'b1;
      end else if (k == ws_of[d] + 1) begin
        r = 1'b1; ab = 1'b0;
      end else begin
        k = k + 1;
      end
      m_act[d] <= a;
      m_rec[d] <= r;
      m_abt[d] <= ab;
      m_own[d] <= o;
      m_k[d]   <= k;
      m_ptr[d] <= p;
      m_dx[d]  <= dx;
    end
  end

  logic     cmp_en = 1'b0;
  logic     auto_mode = 1'b0;
  logic     rand_mode = 1'b0;
  logic     drop_pend [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int       raise_pct [4] = '{0, 0, 0, 0};
  logic [3:0] prev_g = 4'd0;
  int       gq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: compare against the model #1 after the edge, then drive stimulus.
  task automatic step();
    @(posedge clk);
    #1;
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        automatic logic [3:0] eg  = m_act[d] ? (4'b0001 << m_own[d]) : 4'd0;
        automatic logic [3:0] ea  = (m_act[d] && m_rec[d] && !m_abt[d]) ? eg : 4'd0;
        automatic logic       ede = m_act[d] && !m_rec[d] && (m_k[d] >= 1);
        chk($sformatf("model_ctl_d%0d", d),
            {g_o[d], a_o[d], b_o[d], oe_o[d], g1_o[d], g2a_o[d], g2b_o[d]},
            {eg, ea, m_act[d], !m_act[d], ede, !ede, !ede});
        if (m_act[d])
          chk($sformatf("model_bus_d%0d", d), {ms_o[d], dx_o[d]}, {2'(m_own[d]), m_dx[d]});
      end
    end
    if (g_o[0] != 4'd0 && prev_g == 4'd0) begin
      for (int i = 0; i < 4; i++) if (g_o[0][i]) gq.push_back(i);
    end
    prev_g = g_o[0];
    if (auto_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (a_o[0][i]) drop_pend[i] = 1'b1;
        else if (drop_pend[i]) begin
          req[i] = 1'b0;
          drop_pend[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(99, 0) < raise_pct[i])) req[i] = 1'b1;
      end
    end
    if (rand_mode) begin
      dev_sel = 12'($urandom);
      reset   = ($urandom_range(299, 0) == 0);
      if (!reset && b_o[0] && a_o[0] == 4'd0 && $urandom_range(39, 0) == 0)
        req = req & ~g_o[0];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drop_pend[i] = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'd0;
    dev_sel = 12'd0;
    step();
    step();
    chk("reset_state", {g_o[0], a_o[0], ms_o[0], oe_o[0], dx_o[0], g1_o[0], g2a_o[0], g2b_o[0], b_o[0]},
        {4'd0, 4'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Single transaction, WAIT_STATES=2.
    req = 4'b0001; dev_sel = 12'h005;
    step();
    chk("t1_T1_grant", {g_o[0], oe_o[0], g1_o[0], b_o[0]}, {4'b0001, 1'b0, 1'b0, 1'b1});
    step();
    chk("t1_T2_dec", {g1_o[0], g2a_o[0], g2b_o[0], dx_o[0]}, {1'b1, 1'b0, 1'b0, 3'd5});
    step();
    step();
    chk("t1_T4_dec", {g1_o[0], a_o[0]}, {1'b1, 4'd0});
    step();
    chk("t1_T5_ack", {a_o[0], g_o[0], g1_o[0]}, {4'b0001, 4'b0001, 1'b0});
    step();
    chk("t1_T6_idle", {g_o[0], a_o[0], b_o[0], oe_o[0]}, {4'd0, 4'd0, 1'b0, 1'b1});
    req = 4'd0;

    // All four requesting with handshake: rotation 0,1,2,3,0.
    do_reset();
    gq.delete();
    req = 4'hF;
    raise_pct = '{100, 100, 100, 100};
    auto_mode = 1'b1;
    repeat (40) step();
    auto_mode = 1'b0;
    req = 4'd0;
    chk("t2_count", gq.size() >= 5, 1);
    for (int n = 0; n < 5 && n < gq.size(); n++)
      chk($sformatf("t2_order%0d", n), gq[n], n % 4);

    // Requesters 0 and 2 only: alternate 0,2,...
    do_reset();
    gq.delete();
    req = 4'b0101;
    raise_pct = '{100, 0, 100, 0};
    auto_mode = 1'b1;
    repeat (40) step();
    auto_mode = 1'b0;
    req = 4'd0;
    chk("t3_count", gq.size() >= 6, 1);
    for (int n = 0; n < 6 && n < gq.size(); n++)
      chk($sformatf("t3_order%0d", n), gq[n], (n % 2) * 2);

    // Abort of requester 1 in the second strobe cycle.
    do_reset();
    req = 4'b0010;
    step();
    step();
    step();
    req = 4'd0;
    step();
    chk("t4_recover", {g_o[0], a_o[0], g1_o[0], g2a_o[0], b_o[0]}, {4'b0010, 4'd0, 1'b0, 1'b1, 1'b1});
    step();
    chk("t4_idle", {g_o[0], b_o[0]}, {4'd0, 1'b0});
    req = 4'b1001;
    step();
    chk("t4_ptr2", g_o[0], 4'b1000);

    // Reset in the middle of the strobe.
    step();
    reset = 1'b1;
    step();
    chk("t5_reset", {g_o[0], a_o[0], ms_o[0], oe_o[0], dx_o[0], g1_o[0], g2a_o[0], g2b_o[0], b_o[0]},
        {4'd0, 4'd0, 2'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    reset = 1'b0;
    req = 4'b1010;
    step();
    chk("t5_ptr0", g_o[0], 4'b0010);
    req = 4'd0;

    // WAIT_STATES=0, dev_sel churn during strobe.
    do_reset();
    req = 4'b0010; dev_sel = 12'h030;
    step();
    chk("t6_T1_grant", g_o[1], 4'b0010);
    step();
    chk("t6_T2_dec", {g1_o[1], dx_o[1]}, {1'b1, 3'd6});
    dev_sel = 12'hFFF;
    step();
    chk("t6_T3_ack", {a_o[1], dx_o[1], g1_o[1]}, {4'b0010, 3'd6, 1'b0});
    step();
    chk("t6_T4_idle", {g_o[1], b_o[1]}, {4'd0, 1'b0});
    req = 4'd0;

    // Randomized traffic with aborts and occasional resets.
    do_reset();
    for (int i = 0; i < 4; i++) raise_pct[i] = int'($urandom_range(60, 10));
    auto_mode = 1'b1;
    rand_mode = 1'b1;
    repeat (4000) step();
    auto_mode = 1'b0;
    rand_mode = 1'b0;
    reset = 1'b0;
    req = 4'd0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
